// File: rtl/layer_stream_tx.sv
// -----------------------------------------------------------------------------
// layer_stream_tx
//   Transmit side of a layer input stream. For each accepted start it can first
//   stream PARA_WORDS parameter words (mode_in=1), then sends one
//   FM_WIDTH x FM_WIDTH frame of pixel vectors (mode_in=0). Upstream sources
//   use valid/ready. This block inserts the frame sync pulse, the lead-in idle
//   cycles and the idle gaps between rows.
//
// Optional feature macro: LAYER_TX_UNDERRUN_EN
//   defined     : underrun_cnt counts FRAME cycles with pix_valid=0
//                 (saturating, cleared on start accept and on reset)
//   not defined : underrun_cnt is tied to 0
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   start, load_para     start request (sampled in IDLE), parameter phase select
//   para_src_*           parameter word source (valid/ready, signed data)
//   pix_*                pixel vector source (valid/ready, FM_DEPTH elements)
//   mode_in              1 = parameter load, 0 = inference (registered)
//   verticle_sync        one-cycle frame-start pulse (registered)
//   data_in_valid        qualifies data_in / para_in (registered)
//   data_in, para_in     registered pixel vector / parameter word to the layer
//   busy, done           transfer in progress / one-cycle completion pulse
//   underrun_cnt         source starvation counter (see macro above)
// -----------------------------------------------------------------------------
module layer_stream_tx #(
  parameter int FM_DEPTH    = 64,
  parameter int FM_WIDTH    = 56,
  parameter int CHANNEL_NUM = 128,
  parameter int PARA_NUM    = 6,
  parameter int DATA_WIDTH  = 16,
  parameter int PARA_WIDTH  = 16,
  parameter int PARA_WORDS  = FM_DEPTH + (PARA_NUM - 1) * CHANNEL_NUM,
  parameter int VS_LEAD     = 2,
  parameter int ROW_GAP     = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         load_para,
  input  logic                         para_src_valid,
  input  logic signed [PARA_WIDTH-1:0] para_src_data,
  output logic                         para_src_ready,
  input  logic                         pix_valid,
  input  logic signed [DATA_WIDTH-1:0] pix_data [FM_DEPTH],
  output logic                         pix_ready,
  output logic                         mode_in,
  output logic                         verticle_sync,
  output logic                         data_in_valid,
  output logic signed [DATA_WIDTH-1:0] data_in [FM_DEPTH],
  output logic signed [PARA_WIDTH-1:0] para_in,
  output logic                         busy,
  output logic                         done,
  output logic [15:0]                  underrun_cnt
);

  localparam int POS_W    = (FM_WIDTH > 1) ? $clog2(FM_WIDTH) : 1;
  localparam int PCNT_W   = $clog2(PARA_WORDS + 1);
  localparam int WAIT_MAX = (VS_LEAD > ROW_GAP) ? VS_LEAD : ROW_GAP;
  localparam int WAIT_W   = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PARA  = 3'd1,
    ST_VS    = 3'd2,
    ST_LEAD  = 3'd3,
    ST_FRAME = 3'd4,
    ST_GAP   = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

  state_t              state_q, state_d;
  logic [POS_W-1:0]    col_q, col_d;
  logic [POS_W-1:0]    row_q, row_d;
  logic [PCNT_W-1:0]   para_cnt_q, para_cnt_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;

  logic                        mode_q;
  logic                        vsync_q;
  logic                        valid_q;
  logic                        busy_q;
  logic                        done_q;
  logic signed [PARA_WIDTH-1:0] para_q;
  logic signed [DATA_WIDTH-1:0] data_q [FM_DEPTH];

  logic pix_hs_s;
  logic para_hs_s;

  assign pix_hs_s  = pix_ready & pix_valid;
  assign para_hs_s = para_src_ready & para_src_valid;

  // State and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      col_q      <= '0;
      row_q      <= '0;
      para_cnt_q <= '0;
      wait_q     <= '0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      para_cnt_q <= para_cnt_d;
      wait_q     <= wait_d;
    end
  end

  // Next-state logic and source-side ready strobes
  always_comb begin
    state_d        = state_q;
    col_d          = col_q;
    row_d          = row_q;
    para_cnt_d     = para_cnt_q;
    wait_d         = wait_q;
    para_src_ready = 1'b0;
    pix_ready      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          col_d      = '0;
          row_d      = '0;
          para_cnt_d = '0;
          wait_d     = '0;
          state_d    = load_para ? ST_PARA : ST_VS;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PARA: begin
        para_src_ready = 1'b1;
        if (para_src_valid) begin
          if (para_cnt_q == PCNT_W'(PARA_WORDS - 1)) begin
            para_cnt_d = '0;
            state_d    = ST_VS;
          end else begin
            para_cnt_d = para_cnt_q + PCNT_W'(1);
          end
        end else begin
          para_cnt_d = para_cnt_q;
        end
      end
      ST_VS: begin
        wait_d  = '0;
        state_d = (VS_LEAD == 0) ? ST_FRAME : ST_LEAD;
      end
      ST_LEAD: begin
        if (wait_q == WAIT_W'(VS_LEAD - 1)) begin
          wait_d  = '0;
          state_d = ST_FRAME;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ST_FRAME: begin
        pix_ready = 1'b1;
        if (pix_valid) begin
          if (col_q == POS_W'(FM_WIDTH - 1)) begin
            col_d = '0;
            if (row_q == POS_W'(FM_WIDTH - 1)) begin
              state_d = ST_DONE;
            end else begin
              row_d = row_q + POS_W'(1);
              // With no row gap configured the frame simply continues.
              state_d = (ROW_GAP == 0) ? ST_FRAME : ST_GAP;
            end
          end else begin
            col_d = col_q + POS_W'(1);
          end
        end else begin
          col_d = col_q;
        end
      end
      ST_GAP: begin
        if (wait_q == WAIT_W'(ROW_GAP - 1)) begin
          wait_d  = '0;
          state_d = ST_FRAME;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Registered layer-side outputs; data words hold their last value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q  <= 1'b0;
      vsync_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      para_q  <= '0;
      for (int i = 0; i < FM_DEPTH; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      // mode follows the state one cycle late so it stays high alongside the
      // last parameter word and drops on the following cycle.
      mode_q  <= (state_q == ST_PARA);
      vsync_q <= (state_q == ST_VS);
      valid_q <= pix_hs_s | para_hs_s;
      // done lines up with the final pixel's data_in_valid; busy drops after.
      done_q  <= (state_d == ST_DONE);
      busy_q  <= (state_d != ST_IDLE);
      if (para_hs_s) begin
        para_q <= para_src_data;
      end else begin
        para_q <= para_q;
      end
      if (pix_hs_s) begin
        for (int i = 0; i < FM_DEPTH; i++) begin
          data_q[i] <= pix_data[i];
        end
      end else begin
        for (int i = 0; i < FM_DEPTH; i++) begin
          data_q[i] <= data_q[i];
        end
      end
    end
  end

  assign mode_in       = mode_q;
  assign verticle_sync = vsync_q;
  assign data_in_valid = valid_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign para_in       = para_q;
  assign data_in       = data_q;

`ifdef LAYER_TX_UNDERRUN_EN
  logic [15:0] underrun_q;

  // Starvation counter: FRAME cycles without a pixel offered, saturating
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      underrun_q <= 16'd0;
    end else if ((state_q == ST_IDLE) && start) begin
      underrun_q <= 16'd0;
    end else if ((state_q == ST_FRAME) && !pix_valid && (underrun_q != 16'hFFFF)) begin
      underrun_q <= underrun_q + 16'd1;
    end else begin
      underrun_q <= underrun_q;
    end
  end

  assign underrun_cnt = underrun_q;
`else
  assign underrun_cnt = 16'd0;
`endif

endmodule
